// File: rtl/uart_chan_scheduler_if.sv
// Bus between the channel scheduler, the per-channel FIFO read ports and the shared UART transmitter.
// The scheduler uses the master modport; FIFOs and transmitter sit on the slave side.
interface uart_chan_scheduler_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 16
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                     enable;
    logic [NUM_CH-1:0]        empty;
    logic [NUM_CH-1:0]        rd;
    logic [NUM_CH*DATA_W-1:0] fifoOut;
    logic [7:0]               dataBus;
    logic                     ldXmtDataReg;
    logic                     byteReady;
    logic                     tByte;
    logic                     txDone;
    logic                     busy;
    logic [CH_W-1:0]          grantCh;
    logic [15:0]              wordCount;

    modport master (
        input  enable, empty, fifoOut, txDone,
        output rd, dataBus, ldXmtDataReg, byteReady, tByte, busy, grantCh, wordCount
    );

    modport slave (
        output enable, empty, fifoOut, txDone,
        input  rd, dataBus, ldXmtDataReg, byteReady, tByte, busy, grantCh, wordCount
    );
endinterface

// File: rtl/uart_chan_scheduler.sv
// Round-robin scheduler draining up to BURST_LEN 16-bit words per grant into one byte-wide UART transmitter.
// Optional feature macro UART_CHAN_TAG_EN: prefixes every word with a tag byte {4'hA, channel}.
module uart_chan_scheduler #(
    parameter int NUM_CH    = 4,
    parameter int DATA_W    = 16,
    parameter int BURST_LEN = 4
) (
    input  logic                   clk,
    input  logic                   nRST,
    uart_chan_scheduler_if.master  bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
`ifdef UART_CHAN_TAG_EN
    localparam logic [1:0] LAST_IDX = 2'd2;
`else
    localparam logic [1:0] LAST_IDX = 2'd1;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_ARB, S_RD, S_LATCH, S_LD, S_RDY, S_TB, S_WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [CH_W-1:0] grant_q, grant_d;
    logic [CH_W-1:0] ptr_q, ptr_d;
    logic [7:0]      burst_q, burst_d;
    logic [15:0]     word_q, word_d;
    logic [1:0]      byte_idx_q, byte_idx_d;
    logic [15:0]     word_count_q, word_count_d;

    logic [15:0]     ch_word [NUM_CH];
    logic [NUM_CH-1:0] rd_vec;
    logic            arb_found;
    logic [CH_W-1:0] arb_ch;
    logic [CH_W-1:0] cand_idx;
    int              cand;
    logic [7:0]      data_byte;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign ch_word[gi] = bus.fifoOut[gi*DATA_W +: 16];
            assign rd_vec[gi]  = (state_q == S_RD) && (grant_q == CH_W'(gi));
        end
    endgenerate

    // First non-empty channel strictly after the round-robin pointer, wrapping.
    always_comb begin
        arb_found = 1'b0;
        arb_ch    = ptr_q;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= NUM_CH) cand = cand - NUM_CH;
            cand_idx = CH_W'(cand);
            if (!arb_found && !bus.empty[cand_idx]) begin
                arb_found = 1'b1;
                arb_ch    = cand_idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        ptr_d        = ptr_q;
        burst_d      = burst_q;
        word_d       = word_q;
        byte_idx_d   = byte_idx_q;
        word_count_d = word_count_q;
        case (state_q)
            S_IDLE: if (bus.enable && !(&bus.empty)) state_d = S_ARB;
            S_ARB: begin
                if (arb_found) begin
                    grant_d = arb_ch;
                    burst_d = 8'd0;
                    state_d = S_RD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD:    state_d = S_LATCH;
            S_LATCH: begin
                word_d     = ch_word[grant_q];
                byte_idx_d = 2'd0;
                state_d    = S_LD;
            end
            S_LD:  state_d = S_RDY;
            S_RDY: state_d = S_TB;
            S_TB:  state_d = S_WAIT;
            S_WAIT: begin
                if (bus.txDone) begin
                    if (byte_idx_q != LAST_IDX) begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        state_d    = S_LD;
                    end else begin
                        word_count_d = word_count_q + 16'd1;
                        burst_d      = burst_q + 8'd1;
                        // Stay on the channel only if it still has data; never read an empty FIFO.
                        if (bus.enable && (int'(burst_q) + 1 < BURST_LEN) && !bus.empty[grant_q]) begin
                            state_d = S_RD;
                        end else begin
                            ptr_d   = grant_q;
                            state_d = bus.enable ? S_ARB : S_IDLE;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            ptr_q        <= CH_W'(NUM_CH - 1);
            burst_q      <= 8'd0;
            word_q       <= 16'd0;
            byte_idx_q   <= 2'd0;
            word_count_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            ptr_q        <= ptr_d;
            burst_q      <= burst_d;
            word_q       <= word_d;
            byte_idx_q   <= byte_idx_d;
            word_count_q <= word_count_d;
        end
    end

    // Byte is only driven while a byte transfer is in progress, zero otherwise.
    always_comb begin
        data_byte = 8'h00;
        if (state_q inside {S_LD, S_RDY, S_TB, S_WAIT}) begin
`ifdef UART_CHAN_TAG_EN
            case (byte_idx_q)
                2'd0:    data_byte = {4'hA, 4'(grant_q)};
                2'd1:    data_byte = word_q[15:8];
                default: data_byte = word_q[7:0];
            endcase
`else
            data_byte = (byte_idx_q == 2'd0) ? word_q[15:8] : word_q[7:0];
`endif
        end
    end

    assign bus.rd           = rd_vec;
    assign bus.dataBus      = data_byte;
    assign bus.ldXmtDataReg = (state_q == S_LD);
    assign bus.byteReady    = (state_q == S_RDY);
    assign bus.tByte        = (state_q == S_TB);
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.grantCh      = grant_q;
    assign bus.wordCount    = word_count_q;
endmodule

// File: tb/tb_uart_chan_scheduler.sv
// Self-checking bench for uart_chan_scheduler: FIFO and transmitter models, directed vectors and a round-robin reference model.
module tb_uart_chan_scheduler;
    localparam int NUM_CH    = 4;
    localparam int BURST_LEN = 4;
`ifdef UART_CHAN_TAG_EN
    localparam int BPW = 3;
`else
    localparam int BPW = 2;
`endif

    logic clk = 1'b0;
    logic nRST = 1'b0;
    always #5 clk = ~clk;

    uart_chan_scheduler_if #(.NUM_CH(NUM_CH), .DATA_W(16)) bus ();

    uart_chan_scheduler #(.NUM_CH(NUM_CH), .DATA_W(16), .BURST_LEN(BURST_LEN)) dut (
        .clk  (clk),
        .nRST (nRST),
        .bus  (bus)
    );

    typedef struct {
        logic [7:0] b;
        int         ch;
    } rx_t;

    typedef struct {
        logic [15:0] w;
        int          ch;
    } exp_t;

    typedef struct {
        int               ch;
        logic [15:0]      word;
        logic [7:0]       exp_msb;
        logic [7:0]       exp_lsb;
        logic [NUM_CH-1:0] exp_rd;
    } vec_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] fq [NUM_CH][$];
    logic [15:0] fout [NUM_CH];
    rx_t         rx_q [$];
    int          rd_cnt [NUM_CH];
    logic [NUM_CH-1:0] first_rd;
    bit          first_rd_seen;
    int          tx_timer;
    int          tx_lat_min, tx_lat_max;
    bit          noise;
    int          cyc;
    int          ld_cyc;
    bit          ld_seen;
    logic [7:0]  ld_byte;
    vec_t        vecs [5];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive_inputs();
        for (int c = 0; c < NUM_CH; c++) begin
            bus.empty[c]            = (fq[c].size() == 0);
            bus.fifoOut[c*16 +: 16] = fout[c];
        end
    endtask

    // One clock: observe outputs at the falling edge, then update the FIFO and transmitter models.
    task automatic tick();
        int  act;
        rx_t r;
        @(negedge clk);
        cyc++;
        act = $countones(bus.rd) + int'(bus.ldXmtDataReg) + int'(bus.byteReady) + int'(bus.tByte);
        check("strobe_exclusive", 32'(act <= 1), 32'd1);
        for (int c = 0; c < NUM_CH; c++) begin
            if (bus.rd[c]) begin
                check($sformatf("rd_nonempty_ch%0d", c), 32'(fq[c].size() != 0), 32'd1);
                if (fq[c].size() != 0) fout[c] = fq[c].pop_front();
                rd_cnt[c]++;
                if (!first_rd_seen) begin
                    first_rd      = bus.rd;
                    first_rd_seen = 1'b1;
                end
            end
        end
        if (bus.ldXmtDataReg) begin
            ld_byte = bus.dataBus;
            if (!ld_seen) begin
                ld_seen = 1'b1;
                ld_cyc  = cyc;
            end
        end
        if (bus.tByte) begin
            check("databus_stable", bus.dataBus, ld_byte);
            r.b  = bus.dataBus;
            r.ch = int'(bus.grantCh);
            rx_q.push_back(r);
        end
        bus.txDone = 1'b0;
        if (bus.tByte) begin
            tx_timer = int'($urandom_range(tx_lat_max, tx_lat_min));
        end else if (tx_timer > 0) begin
            tx_timer--;
            if (tx_timer == 0) bus.txDone = 1'b1;
        end else if (noise) begin
            bus.txDone = ($urandom_range(3, 0) == 0);
        end
        drive_inputs();
    endtask

    task automatic apply_reset();
        nRST       = 1'b0;
        bus.enable = 1'b0;
        bus.txDone = 1'b0;
        tx_timer   = 0;
        noise      = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            fq[c].delete();
            fout[c]   = 16'h0;
            rd_cnt[c] = 0;
        end
        rx_q.delete();
        first_rd_seen = 1'b0;
        ld_seen       = 1'b0;
        drive_inputs();
        tick();
        tick();
        nRST = 1'b1;
    endtask

    function automatic int total_queued();
        int s = 0;
        for (int c = 0; c < NUM_CH; c++) s += fq[c].size();
        return s;
    endfunction

    task automatic wait_idle(input bit need_empty, input int budget, input string name);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!((!need_empty || total_queued() == 0) && !bus.busy && tx_timer == 0) && n < budget);
        if (n >= budget) check({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    // Reference: walk the channels round-robin from the last grant, taking up to BURST_LEN words each.
    task automatic model_run(input string name, input int budget);
        logic [15:0] mq [NUM_CH][$];
        exp_t        exp_q [$];
        exp_t        e;
        int          ptr = NUM_CH - 1;
        int          left = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            mq[c] = fq[c];
            left += mq[c].size();
        end
        while (left > 0) begin
            int ch = -1;
            for (int i = 1; i <= NUM_CH; i++) begin
                int k = (ptr + i) % NUM_CH;
                if (ch < 0 && mq[k].size() > 0) ch = k;
            end
            for (int n = 0; n < BURST_LEN && mq[ch].size() > 0; n++) begin
                e.w  = mq[ch].pop_front();
                e.ch = ch;
                exp_q.push_back(e);
                left--;
            end
            ptr = ch;
        end
        bus.enable = 1'b1;
        wait_idle(1'b1, budget, name);
        check({name, "_bytes"}, rx_q.size(), exp_q.size() * BPW);
        for (int k = 0; k < exp_q.size(); k++) begin
            if ((k + 1) * BPW <= rx_q.size()) begin
                int          base = k * BPW;
                logic [15:0] got  = {rx_q[base + BPW - 2].b, rx_q[base + BPW - 1].b};
                $display("%s word %0d: ch %0d data %h (expected ch %0d data %h)",
                         name, k, rx_q[base + BPW - 1].ch, got, exp_q[k].ch, exp_q[k].w);
`ifdef UART_CHAN_TAG_EN
                check($sformatf("%s_tag%0d", name, k), rx_q[base].b, {4'hA, 4'(exp_q[k].ch)});
`endif
                check($sformatf("%s_word%0d", name, k), got, exp_q[k].w);
                check($sformatf("%s_ch%0d", name, k), rx_q[base + BPW - 1].ch, exp_q[k].ch);
            end
        end
        check({name, "_wordcount"}, bus.wordCount, 32'(exp_q.size()));
    endtask

    initial begin
        bus.enable  = 1'b0;
        bus.txDone  = 1'b0;
        bus.empty   = '1;
        bus.fifoOut = '0;
        tx_lat_min  = 1;
        tx_lat_max  = 1;
        cyc         = 0;

        vecs[0] = '{0, 16'h1234, 8'h12, 8'h34, 4'b0001};
        vecs[1] = '{1, 16'hBEEF, 8'hBE, 8'hEF, 4'b0010};
        vecs[2] = '{2, 16'h00FF, 8'h00, 8'hFF, 4'b0100};
        vecs[3] = '{3, 16'hBEEF, 8'hBE, 8'hEF, 4'b1000};
        vecs[4] = '{3, 16'hA55A, 8'hA5, 8'h5A, 4'b1000};

        // Reset state
        apply_reset();
        check("rst_rd", bus.rd, 0);
        check("rst_databus", bus.dataBus, 0);
        check("rst_strobes", {bus.ldXmtDataReg, bus.byteReady, bus.tByte}, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_grant", bus.grantCh, 0);
        check("rst_wordcount", bus.wordCount, 0);

        // Single-word vectors, txDone 10 cycles after tByte
        for (int v = 0; v < 5; v++) begin
            int en_cyc;
            apply_reset();
            tx_lat_min = 10;
            tx_lat_max = 10;
            fq[vecs[v].ch].push_back(vecs[v].word);
            drive_inputs();
            en_cyc     = cyc;
            bus.enable = 1'b1;
            wait_idle(1'b1, 300, $sformatf("vec%0d", v));
            $display("vec%0d: ch %0d word %h -> %0d bytes, wordCount %0d", v, vecs[v].ch, vecs[v].word,
                     rx_q.size(), bus.wordCount);
            check($sformatf("vec%0d_latency", v), ld_cyc - en_cyc, 4);
            check($sformatf("vec%0d_rd", v), first_rd, vecs[v].exp_rd);
            check($sformatf("vec%0d_rdcnt", v), rd_cnt[vecs[v].ch], 1);
            check($sformatf("vec%0d_nbytes", v), rx_q.size(), BPW);
            if (rx_q.size() == BPW) begin
`ifdef UART_CHAN_TAG_EN
                check($sformatf("vec%0d_tag", v), rx_q[0].b, {4'hA, 4'(vecs[v].ch)});
`endif
                check($sformatf("vec%0d_msb", v), rx_q[BPW - 2].b, vecs[v].exp_msb);
                check($sformatf("vec%0d_lsb", v), rx_q[BPW - 1].b, vecs[v].exp_lsb);
            end
            check($sformatf("vec%0d_wordcount", v), bus.wordCount, 1);
            check($sformatf("vec%0d_grant", v), bus.grantCh, vecs[v].ch);
        end

        // All channels full: 4-word bursts rotating, then the 2-word remainders
        apply_reset();
        tx_lat_min = 2;
        tx_lat_max = 4;
        for (int c = 0; c < NUM_CH; c++)
            for (int n = 0; n < 6; n++) fq[c].push_back(16'((c << 12) | n | 16'h0A00));
        drive_inputs();
        model_run("all_full", 5000);

        // ch2 holds a single word; next grant moves on to ch3
        apply_reset();
        tx_lat_min = 3;
        tx_lat_max = 3;
        fq[2].push_back(16'h2222);
        fq[3].push_back(16'h3331);
        fq[3].push_back(16'h3332);
        drive_inputs();
        model_run("ch2_short", 1000);
        check("ch2_short_rd2", rd_cnt[2], 1);

        // enable dropped during WAIT of the first byte: word completes, then IDLE with no more reads
        begin
            int n = 0;
            apply_reset();
            tx_lat_min = 5;
            tx_lat_max = 5;
            fq[0].push_back(16'hC0DE);
            fq[0].push_back(16'h1111);
            fq[0].push_back(16'h2222);
            drive_inputs();
            bus.enable = 1'b1;
            while (rx_q.size() == 0 && n < 100) begin
                tick();
                n++;
            end
            check("endrop_first_tbyte_seen", 32'(rx_q.size() > 0), 32'd1);
            tick();
            bus.enable = 1'b0;
            wait_idle(1'b0, 200, "endrop");
            for (int k = 0; k < 30; k++) tick();
            $display("endrop: %0d bytes, %0d reads, wordCount %0d", rx_q.size(), rd_cnt[0], bus.wordCount);
            check("endrop_rdcnt", rd_cnt[0], 1);
            check("endrop_nbytes", rx_q.size(), BPW);
            if (rx_q.size() == BPW) check("endrop_word", {rx_q[BPW - 2].b, rx_q[BPW - 1].b}, 16'hC0DE);
            check("endrop_wordcount", bus.wordCount, 1);
            check("endrop_left", fq[0].size(), 2);
            check("endrop_busy", bus.busy, 0);
        end

        // nRST pulsed during WAIT: outputs clear, word lost, ch0 first after release
        begin
            int n = 0;
            apply_reset();
            tx_lat_min = 8;
            tx_lat_max = 8;
            fq[2].push_back(16'h2A2A);
            fq[2].push_back(16'h2B2B);
            drive_inputs();
            bus.enable = 1'b1;
            while (rx_q.size() == 0 && n < 100) begin
                tick();
                n++;
            end
            tick();
            fq[0].push_back(16'h0F0F);
            drive_inputs();
            #2;
            nRST       = 1'b0;
            tx_timer   = 0;
            bus.txDone = 1'b0;
            tick();
            check("arst_rd", bus.rd, 0);
            check("arst_databus", bus.dataBus, 0);
            check("arst_strobes", {bus.ldXmtDataReg, bus.byteReady, bus.tByte}, 0);
            check("arst_busy", bus.busy, 0);
            check("arst_grant", bus.grantCh, 0);
            check("arst_wordcount", bus.wordCount, 0);
            nRST = 1'b1;
            rx_q.delete();
            first_rd_seen = 1'b0;
            wait_idle(1'b1, 500, "arst");
            $display("arst: first rd %b, ch2 reads %0d, bytes %0d", first_rd, rd_cnt[2], rx_q.size());
            check("arst_first_grant", first_rd, 4'b0001);
            check("arst_ch2_reads", rd_cnt[2], 2);
            check("arst_nbytes", rx_q.size(), 2 * BPW);
            if (rx_q.size() == 2 * BPW) begin
                check("arst_word0", {rx_q[BPW - 2].b, rx_q[BPW - 1].b}, 16'h0F0F);
                check("arst_word1", {rx_q[2 * BPW - 2].b, rx_q[2 * BPW - 1].b}, 16'h2B2B);
            end
            check("arst_wordcount2", bus.wordCount, 2);
        end

        // Randomized fill levels, contents, txDone latency and stray txDone pulses
        for (int it = 0; it < 15; it++) begin
            apply_reset();
            noise      = 1'b1;
            tx_lat_min = 1;
            tx_lat_max = 6;
            for (int c = 0; c < NUM_CH; c++) begin
                int cnt = int'($urandom_range(7, 0));
                for (int n = 0; n < cnt; n++) fq[c].push_back(16'($urandom));
            end
            drive_inputs();
            model_run($sformatf("rand%0d", it), 5000);
            noise = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
